ahb2apb_bridge: RTL and testbench
=================================

// Module: ahb2apb_bridge
// PURPOSE
//  AHB-Lite slave to APB master bridge; sits between the system AHB and the peripheral APB.
//  Accepts NONSEQ/SEQ transfers (single or INCR bursts) and issues a 2-phase APB transfer per beat.
//  Selects one of three APB slaves.
//  Exposes its FSM state on 'states' for monitoring.
// PARAMETERS
//  none.
//  Address map and encodings are fixed constants in ahb2apb_pkg.
// PORTS
//  hclk      in   1   bridge clock; one clock domain, all flops on posedge hclk
//  hresetn   in   1   reset, asynchronous and active-low
//  hwrite    in   1   AHB direction: 1=write, 0=read
//  htrans    in   2   AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  hsize     in   3   AHB size; accepted, not checked
//  hburst    in   3   AHB burst type; accepted, not checked
//  hreadyin  in   1   AHB bus ready
//  haddr     in   32  AHB address
//  hwdata    in   32  AHB write data (data phase)
//  prdata    in   32  APB read data
//  hrdata    out  32  AHB read data = prdata (combinational)
//  hreadyout out  1   bridge ready
//  hresp     out  2   tied to 2'b00 (OKAY)
//  paddr     out  32  APB address
//  pwdata    out  32  APB write data
//  pwrite    out  1   APB direction
//  penable   out  1   APB enable
//  pselx     out  3   one-hot APB slave select
//  states    out  4   current FSM state code
// BEHAVIOUR
//  valid = hreadyin & htrans[1] & (haddr in 0x8000_0000..0x8BFF_FFFF); BUSY/IDLE are never valid.
//  Slave decode: 0x80-0x83 -> pselx 001; 0x84-0x87 -> 010; 0x88-0x8B -> 100 (on haddr[31:24]).
//  Pipeline regs: haddr1<=haddr, haddr2<=haddr1, hwdata1<=hwdata, hwrite_reg<=hwrite, every cycle.
//  States (4-bit codes): IDLE 0000, WWAIT 0001, READ 0010, WRITE 0011, WRITEP 0100,
//    RENABLE 0101, WENABLE 0110, WENABLEP 0111.
//  Transitions:
//   IDLE:   valid&hwrite->WWAIT; valid&!hwrite->READ; else IDLE
//   WWAIT:  valid->WRITEP; else WRITE
//   READ:   ->RENABLE
//   WRITE:  valid->WENABLEP; else WENABLE
//   WRITEP: ->WENABLEP
//   RENABLE, WENABLE: valid&!hwrite->READ; valid&hwrite->WWAIT; else IDLE
//   WENABLEP: hwrite_reg&valid->WRITEP; hwrite_reg&!valid->WRITE; !hwrite_reg->READ
//  APB outputs are registered and take their values on entry to the state:
//   ->READ: paddr=haddr, pselx=decode(haddr), pwrite=0, penable=0, hreadyout=0
//   ->WRITE/WRITEP: paddr=haddr1 (WRITEP from WENABLEP: haddr2), pwdata=hwdata, pwrite=1,
//     pselx=decode(paddr), penable=0, hreadyout=0
//   ->RENABLE/WENABLE/WENABLEP: penable=1, other APB outputs held, hreadyout=1
//   ->IDLE/WWAIT: pselx=000, penable=0, hreadyout=1; paddr/pwdata/pwrite held
//  Latency: single read = 2 APB cycles after address phase; single write = 1 wait cycle + 2 APB cycles.
//  Reset (async, any time, incl. mid-transfer): state=IDLE, paddr=0, pwdata=0, pwrite=0,
//   penable=0, pselx=000, hreadyout=1, pipeline regs=0; any in-flight transfer is dropped.
//  An out-of-range address is ignored (no pselx, no error response).
// STRUCTURE
//  ahb2apb_pkg:
//   - state_t enum (codes above)
//   - HTRANS_* constants
//   - slave base/limit address constants
//  Sub-module ahb_slave_if: pipeline regs, valid, pselx decode.
//  FSM and APB output regs in ahb2apb_bridge.
// TESTING
//  1. Reset: hresetn=0 -> states=0000, pselx=000, penable=0, hreadyout=1.
//  2. Single write: haddr=0x8000_0001, hwrite=1, NONSEQ, then hwdata=0xA300_1111
//     -> WWAIT, WRITE (paddr=0x8000_0001, pselx=001, pwrite=1), WENABLE (penable=1), IDLE.
//  3. Single read: haddr=0x8000_00A2, hwrite=0, prdata=0x1234_5678
//     -> READ, RENABLE; hrdata=0x1234_5678 while penable=1.
//  4. Burst read: INCR4 at 0x8000_00C0, 4 SEQ beats
//     -> alternating READ/RENABLE, pwrite=0, hreadyout low in each READ.
//  5. Burst write: INCR4 at 0x8000_00FF
//     -> WWAIT, WRITEP, WENABLEP chain, then WRITE/WENABLE at end, back to IDLE.
//  6. Decode/invalid: haddr=0x8400_0000 -> pselx=010; haddr=0x9000_0000 or htrans=BUSY
//     -> stays IDLE.
//     hresetn low mid-burst -> immediate IDLE outputs.

Source files
------------

// File: rtl/ahb2apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB bridge: state codes,
// AHB transfer encodings and the fixed three-slave APB address map.
package ahb2apb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0000,
    ST_WWAIT    = 4'b0001,
    ST_READ     = 4'b0010,
    ST_WRITE    = 4'b0011,
    ST_WRITEP   = 4'b0100,
    ST_RENABLE  = 4'b0101,
    ST_WENABLE  = 4'b0110,
    ST_WENABLEP = 4'b0111
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [31:0] SLV0_BASE  = 32'h8000_0000;
  localparam logic [31:0] SLV0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] SLV1_BASE  = 32'h8400_0000;
  localparam logic [31:0] SLV1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] SLV2_BASE  = 32'h8800_0000;
  localparam logic [31:0] SLV2_LIMIT = 32'h8BFF_FFFF;

  // One-hot slave select; an address outside the map selects nobody.
  function automatic logic [2:0] decode_sel(input logic [31:0] addr);
    logic [2:0] sel;
    sel = 3'b000;
    if (addr >= SLV0_BASE && addr <= SLV0_LIMIT)      sel = 3'b001;
    else if (addr >= SLV1_BASE && addr <= SLV1_LIMIT) sel = 3'b010;
    else if (addr >= SLV2_BASE && addr <= SLV2_LIMIT) sel = 3'b100;
    return sel;
  endfunction

endpackage

// File: rtl/ahb_slave_if.sv
// AHB-side front end: address/data/direction pipeline registers, transfer
// qualification and slave select decode of the live address.
module ahb_slave_if
  import ahb2apb_pkg::*;
(
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic        hreadyin,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic        valid,
  output logic [2:0]  tempselx,
  output logic [31:0] haddr1,
  output logic [31:0] haddr2,
  output logic [31:0] hwdata1,
  output logic        hwrite_reg
);

  logic in_map;

  assign in_map   = (haddr >= SLV0_BASE) && (haddr <= SLV2_LIMIT);
  // htrans[1] is set only for NONSEQ/SEQ, so IDLE and BUSY never qualify.
  assign valid    = hreadyin && htrans[1] && in_map;
  assign tempselx = decode_sel(haddr);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr1     <= '0;
      haddr2     <= '0;
      hwdata1    <= '0;
      hwrite_reg <= 1'b0;
    end else begin
      haddr1     <= haddr;
      haddr2     <= haddr1;
      hwdata1    <= hwdata;
      hwrite_reg <= hwrite;
    end
  end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge: one two-phase APB transfer per AHB
// beat, with registered APB outputs loaded on entry to each FSM state.
module ahb2apb_bridge
  import ahb2apb_pkg::*;
(
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic        hreadyin,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic [31:0] prdata,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        pwrite,
  output logic        penable,
  output logic [2:0]  pselx,
  output logic [3:0]  states
);

  logic        valid;
  logic [2:0]  tempselx;
  logic [31:0] haddr1;
  logic [31:0] haddr2;
  logic [31:0] hwdata1;
  logic        hwrite_reg;

  state_t      state_reg, state_next;
  logic [31:0] paddr_reg, paddr_next;
  logic [31:0] pwdata_reg, pwdata_next;
  logic        pwrite_reg, pwrite_next;
  logic        penable_reg, penable_next;
  logic [2:0]  pselx_reg, pselx_next;
  logic        hreadyout_reg, hreadyout_next;
  logic [31:0] waddr;
  logic        unused_ok;

  ahb_slave_if u_ahb_slave_if (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .hwrite     (hwrite),
    .htrans     (htrans),
    .hreadyin   (hreadyin),
    .haddr      (haddr),
    .hwdata     (hwdata),
    .valid      (valid),
    .tempselx   (tempselx),
    .haddr1     (haddr1),
    .haddr2     (haddr2),
    .hwdata1    (hwdata1),
    .hwrite_reg (hwrite_reg)
  );

  assign unused_ok = ^{hsize, hburst, hwdata1};

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (valid && hwrite)       state_next = ST_WWAIT;
        else if (valid)            state_next = ST_READ;
        else                       state_next = ST_IDLE;
      end
      ST_WWAIT:    state_next = valid ? ST_WRITEP : ST_WRITE;
      ST_READ:     state_next = ST_RENABLE;
      ST_WRITE:    state_next = valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP:   state_next = ST_WENABLEP;
      ST_RENABLE,
      ST_WENABLE: begin
        if (valid && !hwrite)      state_next = ST_READ;
        else if (valid && hwrite)  state_next = ST_WWAIT;
        else                       state_next = ST_IDLE;
      end
      ST_WENABLEP: begin
        if (!hwrite_reg)           state_next = ST_READ;
        else if (valid)            state_next = ST_WRITEP;
        else                       state_next = ST_WRITE;
      end
      default:     state_next = ST_IDLE;
    endcase
  end

  // After a pipelined write phase the pending beat's address is two stages back.
  always_comb begin
    waddr          = (state_reg == ST_WENABLEP) ? haddr2 : haddr1;
    paddr_next     = paddr_reg;
    pwdata_next    = pwdata_reg;
    pwrite_next    = pwrite_reg;
    penable_next   = penable_reg;
    pselx_next     = pselx_reg;
    hreadyout_next = hreadyout_reg;
    unique case (state_next)
      ST_READ: begin
        paddr_next     = haddr;
        pselx_next     = tempselx;
        pwrite_next    = 1'b0;
        penable_next   = 1'b0;
        hreadyout_next = 1'b0;
      end
      ST_WRITE, ST_WRITEP: begin
        paddr_next     = waddr;
        pwdata_next    = hwdata;
        pwrite_next    = 1'b1;
        pselx_next     = decode_sel(waddr);
        penable_next   = 1'b0;
        hreadyout_next = 1'b0;
      end
      ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
        penable_next   = 1'b1;
        hreadyout_next = 1'b1;
      end
      default: begin
        pselx_next     = 3'b000;
        penable_next   = 1'b0;
        hreadyout_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_reg     <= ST_IDLE;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      pwrite_reg    <= 1'b0;
      penable_reg   <= 1'b0;
      pselx_reg     <= 3'b000;
      hreadyout_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      paddr_reg     <= paddr_next;
      pwdata_reg    <= pwdata_next;
      pwrite_reg    <= pwrite_next;
      penable_reg   <= penable_next;
      pselx_reg     <= pselx_next;
      hreadyout_reg <= hreadyout_next;
    end
  end

  assign hrdata    = prdata;
  assign hresp     = 2'b00;
  assign paddr     = paddr_reg;
  assign pwdata    = pwdata_reg;
  assign pwrite    = pwrite_reg;
  assign penable   = penable_reg;
  assign pselx     = pselx_reg;
  assign hreadyout = hreadyout_reg;
  assign states    = state_reg;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed bench for ahb2apb_bridge: per-cycle AHB vectors with hand-computed
// FSM state and APB outputs.
module tb_ahb2apb_bridge;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hreadyin;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] prdata;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        penable;
  logic [2:0]  pselx;
  logic [3:0]  states;

  int n_cmp = 0;
  int n_err = 0;
  int n_cyc = 0;

  ahb2apb_bridge dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hwrite    (hwrite),
    .htrans    (htrans),
    .hsize     (hsize),
    .hburst    (hburst),
    .hreadyin  (hreadyin),
    .haddr     (haddr),
    .hwdata    (hwdata),
    .prdata    (prdata),
    .hrdata    (hrdata),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pwrite    (pwrite),
    .penable   (penable),
    .pselx     (pselx),
    .states    (states)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one AHB cycle, clock it, then check state and the handshake outputs.
  task automatic cyc(input string tag, input logic [1:0] tr, input logic wr,
                     input logic [31:0] a, input logic [31:0] wd, input logic rdy,
                     input logic [3:0] est, input logic [2:0] esel,
                     input logic epen, input logic ehro);
    htrans   = tr;
    hwrite   = wr;
    haddr    = a;
    hwdata   = wd;
    hreadyin = rdy;
    @(posedge hclk);
    #1;
    n_cyc++;
    $display("cyc %0d %s: htrans=%b hwrite=%b haddr=%08h -> state=%0d pselx=%b penable=%b hreadyout=%b paddr=%08h pwdata=%08h",
             n_cyc, tag, tr, wr, a, states, pselx, penable, hreadyout, paddr, pwdata);
    check({tag, ".state"}, {28'd0, states}, {28'd0, est});
    check({tag, ".pselx"}, {29'd0, pselx}, {29'd0, esel});
    check({tag, ".penable"}, {31'd0, penable}, {31'd0, epen});
    check({tag, ".hreadyout"}, {31'd0, hreadyout}, {31'd0, ehro});
  endtask

  localparam logic [1:0] TI = 2'b00, TB = 2'b01, TN = 2'b10, TS = 2'b11;

  initial begin
    hresetn = 1'b0; hwrite = 1'b0; htrans = TI; hsize = 3'b010; hburst = 3'b000;
    hreadyin = 1'b1; haddr = '0; hwdata = '0; prdata = 32'h1234_5678;

    // Reset state
    repeat (2) @(posedge hclk);
    #1;
    check("rst.state", {28'd0, states}, 32'd0);
    check("rst.pselx", {29'd0, pselx}, 32'd0);
    check("rst.penable", {31'd0, penable}, 32'd0);
    check("rst.hreadyout", {31'd0, hreadyout}, 32'd1);
    check("rst.paddr", paddr, 32'd0);
    check("rst.hresp", {30'd0, hresp}, 32'd0);
    hresetn = 1'b1;

    // Single write
    cyc("wr0", TN, 1'b1, 32'h8000_0001, 32'h0, 1'b1, 4'd1, 3'b000, 1'b0, 1'b1);
    cyc("wr1", TI, 1'b1, 32'h0, 32'hA300_1111, 1'b1, 4'd3, 3'b001, 1'b0, 1'b0);
    check("wr1.paddr", paddr, 32'h8000_0001);
    check("wr1.pwdata", pwdata, 32'hA300_1111);
    check("wr1.pwrite", {31'd0, pwrite}, 32'd1);
    cyc("wr2", TI, 1'b1, 32'h0, 32'h0, 1'b1, 4'd6, 3'b001, 1'b1, 1'b1);
    cyc("wr3", TI, 1'b1, 32'h0, 32'h0, 1'b1, 4'd0, 3'b000, 1'b0, 1'b1);
    check("wr3.paddr_held", paddr, 32'h8000_0001);

    // Single read
    cyc("rd0", TN, 1'b0, 32'h8000_00A2, 32'h0, 1'b1, 4'd2, 3'b001, 1'b0, 1'b0);
    check("rd0.paddr", paddr, 32'h8000_00A2);
    check("rd0.pwrite", {31'd0, pwrite}, 32'd0);
    cyc("rd1", TI, 1'b0, 32'h0, 32'h0, 1'b1, 4'd5, 3'b001, 1'b1, 1'b1);
    check("rd1.hrdata", hrdata, 32'h1234_5678);
    cyc("rd2", TI, 1'b0, 32'h0, 32'h0, 1'b1, 4'd0, 3'b000, 1'b0, 1'b1);

    // INCR4 read; hreadyin mirrors the bridge's hreadyout
    hburst = 3'b011;
    prdata = 32'hCAFE_0001;
    cyc("br0", TN, 1'b0, 32'h8000_00C0, 32'h0, 1'b1, 4'd2, 3'b001, 1'b0, 1'b0);
    check("br0.paddr", paddr, 32'h8000_00C0);
    cyc("br1", TS, 1'b0, 32'h8000_00C4, 32'h0, 1'b0, 4'd5, 3'b001, 1'b1, 1'b1);
    check("br1.hrdata", hrdata, 32'hCAFE_0001);
    cyc("br2", TS, 1'b0, 32'h8000_00C4, 32'h0, 1'b1, 4'd2, 3'b001, 1'b0, 1'b0);
    check("br2.paddr", paddr, 32'h8000_00C4);
    cyc("br3", TS, 1'b0, 32'h8000_00C8, 32'h0, 1'b0, 4'd5, 3'b001, 1'b1, 1'b1);
    cyc("br4", TS, 1'b0, 32'h8000_00C8, 32'h0, 1'b1, 4'd2, 3'b001, 1'b0, 1'b0);
    check("br4.paddr", paddr, 32'h8000_00C8);
    cyc("br5", TS, 1'b0, 32'h8000_00CC, 32'h0, 1'b0, 4'd5, 3'b001, 1'b1, 1'b1);
    cyc("br6", TS, 1'b0, 32'h8000_00CC, 32'h0, 1'b1, 4'd2, 3'b001, 1'b0, 1'b0);
    check("br6.paddr", paddr, 32'h8000_00CC);
    check("br6.pwrite", {31'd0, pwrite}, 32'd0);
    cyc("br7", TI, 1'b0, 32'h0, 32'h0, 1'b0, 4'd5, 3'b001, 1'b1, 1'b1);
    cyc("br8", TI, 1'b0, 32'h0, 32'h0, 1'b1, 4'd0, 3'b000, 1'b0, 1'b1);

    // INCR4 write at 0x800000FF; data lags address by one accepted beat
    cyc("bw0", TN, 1'b1, 32'h8000_00FF, 32'h0, 1'b1, 4'd1, 3'b000, 1'b0, 1'b1);
    cyc("bw1", TS, 1'b1, 32'h8000_0103, 32'hD000_0000, 1'b1, 4'd4, 3'b001, 1'b0, 1'b0);
    check("bw1.paddr", paddr, 32'h8000_00FF);
    check("bw1.pwdata", pwdata, 32'hD000_0000);
    cyc("bw2", TS, 1'b1, 32'h8000_0107, 32'hD000_0001, 1'b0, 4'd7, 3'b001, 1'b1, 1'b1);
    cyc("bw3", TS, 1'b1, 32'h8000_0107, 32'hD000_0001, 1'b1, 4'd4, 3'b001, 1'b0, 1'b0);
    check("bw3.paddr", paddr, 32'h8000_0103);
    check("bw3.pwdata", pwdata, 32'hD000_0001);
    cyc("bw4", TS, 1'b1, 32'h8000_010B, 32'hD000_0002, 1'b0, 4'd7, 3'b001, 1'b1, 1'b1);
    cyc("bw5", TS, 1'b1, 32'h8000_010B, 32'hD000_0002, 1'b1, 4'd4, 3'b001, 1'b0, 1'b0);
    check("bw5.paddr", paddr, 32'h8000_0107);
    check("bw5.pwdata", pwdata, 32'hD000_0002);
    cyc("bw6", TI, 1'b1, 32'h0, 32'hD000_0003, 1'b0, 4'd7, 3'b001, 1'b1, 1'b1);
    cyc("bw7", TI, 1'b1, 32'h0, 32'hD000_0003, 1'b1, 4'd3, 3'b001, 1'b0, 1'b0);
    check("bw7.paddr", paddr, 32'h8000_010B);
    check("bw7.pwdata", pwdata, 32'hD000_0003);
    check("bw7.pwrite", {31'd0, pwrite}, 32'd1);
    cyc("bw8", TI, 1'b1, 32'h0, 32'h0, 1'b0, 4'd6, 3'b001, 1'b1, 1'b1);
    cyc("bw9", TI, 1'b1, 32'h0, 32'h0, 1'b1, 4'd0, 3'b000, 1'b0, 1'b1);

    // Slave decode and map edges
    hburst = 3'b000;
    cyc("dec1", TN, 1'b0, 32'h8400_0000, 32'h0, 1'b1, 4'd2, 3'b010, 1'b0, 1'b0);
    cyc("dec1e", TI, 1'b0, 32'h0, 32'h0, 1'b1, 4'd5, 3'b010, 1'b1, 1'b1);
    cyc("dec1i", TI, 1'b0, 32'h0, 32'h0, 1'b1, 4'd0, 3'b000, 1'b0, 1'b1);
    cyc("dec2", TN, 1'b0, 32'h8BFF_FFFF, 32'h0, 1'b1, 4'd2, 3'b100, 1'b0, 1'b0);
    check("dec2.paddr", paddr, 32'h8BFF_FFFF);
    cyc("dec2e", TI, 1'b0, 32'h0, 32'h0, 1'b1, 4'd5, 3'b100, 1'b1, 1'b1);
    cyc("dec2i", TI, 1'b0, 32'h0, 32'h0, 1'b1, 4'd0, 3'b000, 1'b0, 1'b1);
    cyc("dec0", TN, 1'b0, 32'h83FF_FFFF, 32'h0, 1'b1, 4'd2, 3'b001, 1'b0, 1'b0);
    cyc("dec0e", TI, 1'b0, 32'h0, 32'h0, 1'b1, 4'd5, 3'b001, 1'b1, 1'b1);
    cyc("dec0i", TI, 1'b0, 32'h0, 32'h0, 1'b1, 4'd0, 3'b000, 1'b0, 1'b1);

    // Transfers that must be ignored
    cyc("inv90", TN, 1'b0, 32'h9000_0000, 32'h0, 1'b1, 4'd0, 3'b000, 1'b0, 1'b1);
    cyc("inv8c", TN, 1'b1, 32'h8C00_0000, 32'h0, 1'b1, 4'd0, 3'b000, 1'b0, 1'b1);
    cyc("inv7f", TN, 1'b0, 32'h7FFF_FFFF, 32'h0, 1'b1, 4'd0, 3'b000, 1'b0, 1'b1);
    cyc("busy", TB, 1'b0, 32'h8000_0000, 32'h0, 1'b1, 4'd0, 3'b000, 1'b0, 1'b1);
    cyc("nrdy", TN, 1'b1, 32'h8000_0000, 32'h0, 1'b0, 4'd0, 3'b000, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a read burst
    cyc("mr0", TN, 1'b0, 32'h8400_0010, 32'h0, 1'b1, 4'd2, 3'b010, 1'b0, 1'b0);
    #2;
    hresetn = 1'b0;
    #1;
    check("mrst.state", {28'd0, states}, 32'd0);
    check("mrst.pselx", {29'd0, pselx}, 32'd0);
    check("mrst.penable", {31'd0, penable}, 32'd0);
    check("mrst.hreadyout", {31'd0, hreadyout}, 32'd1);
    check("mrst.paddr", paddr, 32'd0);
    check("mrst.pwdata", pwdata, 32'd0);
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    cyc("post", TI, 1'b0, 32'h0, 32'h0, 1'b1, 4'd0, 3'b000, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
